// File: rtl/hpu_stream_pivot_pkg.sv
// hpu_stream_pivot shared types: FSM states, selection modes, magnitude helper.
// Optional statistics outputs are enabled with `define HPU_PIVOT_STATS_EN.
package hpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_LOAD = 3'b010,
        S_OUT  = 3'b100
    } state_e;

    typedef enum logic {
        MODE_MAX_ABS    = 1'b0,
        MODE_FIRST_QUAL = 1'b1
    } pivot_mode_e;

    // Unsigned magnitude of a sign-extended value; callers narrow the result.
    // The most negative value maps to its unsigned magnitude, no saturation.
    function automatic logic [63:0] abs_mag(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/hpu_stream_pivot_if.sv
// Bus bundle for hpu_stream_pivot: control, candidate stream, result.
// Stats signals exist only with `define HPU_PIVOT_STATS_EN.
interface hpu_stream_pivot_if #(
    parameter int DATA_W    = 32,
    parameter int ROW_IDX_W = 16,
    parameter int LANES     = 4,
    parameter int CNT_W     = 16
) ();
    logic                       pivot_start;
    logic                       pivot_mode;
    logic [DATA_W-1:0]          pivot_tol;
    logic                       pivot_abort;
    logic                       pivot_busy;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES-1:0]           in_lane_en;
    logic [LANES*DATA_W-1:0]    in_value;
    logic [LANES*ROW_IDX_W-1:0] in_row;
    logic                       in_last;
    logic                       pivot_valid;
    logic                       pivot_ready;
    logic [ROW_IDX_W-1:0]       pivot_row;
    logic [DATA_W-1:0]          pivot_value;
    logic                       pivot_fail;
`ifdef HPU_PIVOT_STATS_EN
    logic [CNT_W-1:0]           pivot_count;
    logic [CNT_W-1:0]           pivot_first_beat;
`endif

    modport slave (
        input  pivot_start, pivot_mode, pivot_tol, pivot_abort,
        output pivot_busy,
        input  in_valid, in_lane_en, in_value, in_row, in_last,
        output in_ready,
        output pivot_valid, pivot_row, pivot_value, pivot_fail,
`ifdef HPU_PIVOT_STATS_EN
        output pivot_count, pivot_first_beat,
`endif
        input  pivot_ready
    );

    modport master (
        output pivot_start, pivot_mode, pivot_tol, pivot_abort,
        input  pivot_busy,
        output in_valid, in_lane_en, in_value, in_row, in_last,
        input  in_ready,
        input  pivot_valid, pivot_row, pivot_value, pivot_fail,
`ifdef HPU_PIVOT_STATS_EN
        input  pivot_count, pivot_first_beat,
`endif
        output pivot_ready
    );

endinterface

// File: rtl/hpu_lane_reduce.sv
// Combinational binary-tree reduction of one beat to its winning lane.
// Lower lane wins ties; FIRST_QUAL takes the lowest qualifying lane.
module hpu_lane_reduce
    import hpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ROW_IDX_W = 16,
    parameter int LANES     = 4,
    parameter int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*DATA_W-1:0]    value,
    input  logic [LANES*ROW_IDX_W-1:0] row,
    input  logic [LANES-1:0]           lane_en,
    input  logic [DATA_W-1:0]          tol,
    input  pivot_mode_e                mode,
    output logic                       win_found,
    output logic [DATA_W-1:0]          win_mag,
    output logic [DATA_W-1:0]          win_value,
    output logic [ROW_IDX_W-1:0]       win_row,
    output logic [LANE_W-1:0]          win_lane
);
    localparam int P = 1 << $clog2(LANES);

    for (genvar n = 0; n < 2*P-1; n++) begin : g_node
        logic                 f;
        logic [DATA_W-1:0]    m;
        logic [DATA_W-1:0]    v;
        logic [ROW_IDX_W-1:0] r;
        logic [LANE_W-1:0]    l;
        if (n >= P-1) begin : g_leaf
            localparam int I = n - (P-1);
            if (I < LANES) begin : g_real
                assign v = value[I*DATA_W +: DATA_W];
                assign m = DATA_W'(abs_mag(64'(signed'(v))));
                assign r = row[I*ROW_IDX_W +: ROW_IDX_W];
                assign l = LANE_W'(I);
                assign f = lane_en[I] && (v != '0) && (m >= tol);
            end else begin : g_pad
                assign v = '0;
                assign m = '0;
                assign r = '0;
                assign l = '0;
                assign f = 1'b0;
            end
        end else begin : g_inner
            logic pick_r;
            assign pick_r = g_node[2*n+2].f &&
                (!g_node[2*n+1].f ||
                 (mode == MODE_MAX_ABS &&
                  g_node[2*n+2].m > g_node[2*n+1].m));
            assign f = g_node[2*n+1].f | g_node[2*n+2].f;
            assign m = pick_r ? g_node[2*n+2].m : g_node[2*n+1].m;
            assign v = pick_r ? g_node[2*n+2].v : g_node[2*n+1].v;
            assign r = pick_r ? g_node[2*n+2].r : g_node[2*n+1].r;
            assign l = pick_r ? g_node[2*n+2].l : g_node[2*n+1].l;
        end
    end

    assign win_found = g_node[0].f;
    assign win_mag   = g_node[0].m;
    assign win_value = g_node[0].v;
    assign win_row   = g_node[0].r;
    assign win_lane  = g_node[0].l;

endmodule

// File: rtl/hpu_stream_pivot.sv
// Streaming pivot search: reduces LANES candidates per beat to a running best.
// Optional stats outputs enabled with `define HPU_PIVOT_STATS_EN.
module hpu_stream_pivot
    import hpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ROW_IDX_W = 16,
    parameter int LANES     = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hpu_stream_pivot_if.slave bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e               state;
    pivot_mode_e          mode_r;
    logic [DATA_W-1:0]    tol_r;
    logic                 best_found;
    logic [DATA_W-1:0]    best_mag;
    logic [DATA_W-1:0]    best_val;
    logic [ROW_IDX_W-1:0] best_row;
    logic [CNT_W-1:0]     count;
    logic                 valid_r;
    logic                 fail_r;
    logic [ROW_IDX_W-1:0] row_r;
    logic [DATA_W-1:0]    val_r;

    logic                 win_found;
    logic [DATA_W-1:0]    win_mag;
    logic [DATA_W-1:0]    win_value;
    logic [ROW_IDX_W-1:0] win_row;
    logic [LANE_W-1:0]    win_lane;
    logic                 unused_lane;

    logic                 accept;
    logic                 take;
    logic                 nb_found;
    logic [DATA_W-1:0]    nb_mag;
    logic [DATA_W-1:0]    nb_val;
    logic [ROW_IDX_W-1:0] nb_row;
    logic [CNT_W:0]       pop;
    logic [CNT_W:0]       sum;
    logic [CNT_W-1:0]     nb_count;

    hpu_lane_reduce #(
        .DATA_W    (DATA_W),
        .ROW_IDX_W (ROW_IDX_W),
        .LANES     (LANES),
        .LANE_W    (LANE_W)
    ) u_reduce (
        .value     (bus.in_value),
        .row       (bus.in_row),
        .lane_en   (bus.in_lane_en),
        .tol       (tol_r),
        .mode      (mode_r),
        .win_found (win_found),
        .win_mag   (win_mag),
        .win_value (win_value),
        .win_row   (win_row),
        .win_lane  (win_lane)
    );

    assign unused_lane = ^win_lane;

    // Merge the beat winner into the running best and the saturating count.
    always_comb begin
        accept = bus.in_valid && (state == S_LOAD);
        take   = win_found &&
                 ((mode_r == MODE_MAX_ABS) ?
                  (!best_found || win_mag > best_mag) : !best_found);
        nb_found = best_found | take;
        nb_mag   = take ? win_mag   : best_mag;
        nb_val   = take ? win_value : best_val;
        nb_row   = take ? win_row   : best_row;
        pop = '0;
        for (int i = 0; i < LANES; i++)
            pop = pop + (CNT_W+1)'(bus.in_lane_en[i]);
        sum      = {1'b0, count} + pop;
        nb_count = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

`ifdef HPU_PIVOT_STATS_EN
    logic [CNT_W-1:0] beat_idx;
    logic [CNT_W-1:0] best_beat;
    logic [CNT_W-1:0] nb_beat;
    logic [CNT_W-1:0] cnt_out_r;
    logic [CNT_W-1:0] beat_out_r;

    assign nb_beat = take ? beat_idx : best_beat;

    // Track beat index of the winner and register stats with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx   <= '0;
            best_beat  <= '0;
            cnt_out_r  <= '0;
            beat_out_r <= '0;
        end else if (state == S_IDLE && bus.pivot_start) begin
            beat_idx  <= '0;
            best_beat <= '0;
        end else if (accept && !bus.pivot_abort) begin
            if (beat_idx != '1)
                beat_idx <= beat_idx + 1'b1;
            best_beat <= nb_beat;
            if (bus.in_last) begin
                cnt_out_r  <= nb_count;
                beat_out_r <= nb_found ? nb_beat : '0;
            end
        end
    end

    assign bus.pivot_count      = cnt_out_r;
    assign bus.pivot_first_beat = beat_out_r;
`endif

    // Round FSM: latch config, accumulate beats, hold result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_r     <= MODE_MAX_ABS;
            tol_r      <= '0;
            best_found <= 1'b0;
            best_mag   <= '0;
            best_val   <= '0;
            best_row   <= '0;
            count      <= '0;
            valid_r    <= 1'b0;
            fail_r     <= 1'b0;
            row_r      <= '0;
            val_r      <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.pivot_start) begin
                    mode_r     <= pivot_mode_e'(bus.pivot_mode);
                    tol_r      <= bus.pivot_tol;
                    best_found <= 1'b0;
                    best_mag   <= '0;
                    best_val   <= '0;
                    best_row   <= '0;
                    count      <= '0;
                    state      <= S_LOAD;
                end
                S_LOAD: if (bus.pivot_abort) begin
                    state <= S_IDLE;
                end else if (accept) begin
                    best_found <= nb_found;
                    best_mag   <= nb_mag;
                    best_val   <= nb_val;
                    best_row   <= nb_row;
                    count      <= nb_count;
                    if (bus.in_last) begin
                        valid_r <= 1'b1;
                        fail_r  <= ~nb_found;
                        row_r   <= nb_found ? nb_row : '0;
                        val_r   <= nb_found ? nb_val : '0;
                        state   <= S_OUT;
                    end
                end
                S_OUT: if (bus.pivot_ready) begin
                    valid_r <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == S_LOAD);
    assign bus.pivot_busy  = (state != S_IDLE);
    assign bus.pivot_valid = valid_r;
    assign bus.pivot_fail  = fail_r;
    assign bus.pivot_row   = row_r;
    assign bus.pivot_value = val_r;

endmodule
